// File: rtl/hermitian_transpose_stream.sv
// Streaming NxN complex matrix pass/transpose/conjugate/Hermitian unit behind a 2-entry FIFO.
// One cycle accept-to-output when empty; in_ready drops only when both slots are occupied.
module hermitian_transpose_stream #(
  parameter int N  = 2,
  parameter int DW = 16,
  localparam int EW = 2 * DW,
  localparam int MW = N * N * EW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [MW-1:0] in_data,
  input  logic [1:0]    in_mode,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [MW-1:0] out_data,
  output logic          sat_flag,
  input  logic          sat_clr,
  output logic [15:0]   mat_cnt
);

  localparam logic [DW-1:0] IM_MIN = {1'b1, {(DW-1){1'b0}}};
  localparam logic [DW-1:0] IM_MAX = {1'b0, {(DW-1){1'b1}}};

  logic          do_tr, do_cj;
  logic [MW-1:0] xf_data;
  logic          xf_sat;
  logic [EW-1:0] elem;
  logic [DW-1:0] re, im;
  int            src;

  // Modes 01 and 10 transpose; modes 10 and 11 conjugate.
  assign do_tr = in_mode[0] ^ in_mode[1];
  assign do_cj = in_mode[1];

  always_comb begin
    xf_data = '0;
    xf_sat  = 1'b0;
    elem    = '0;
    re      = '0;
    im      = '0;
    src     = 0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        src  = do_tr ? (c * N + r) : (r * N + c);
        elem = in_data[MW-1-src*EW -: EW];
        re   = elem[EW-1:DW];
        im   = elem[DW-1:0];
        if (do_cj) begin
          if (im == IM_MIN) begin
            im     = IM_MAX;
            xf_sat = 1'b1;
          end else begin
            im = -im;
          end
        end
        xf_data[MW-1-(r*N+c)*EW -: EW] = {re, im};
      end
    end
  end

  logic [MW-1:0] mem [2];
  logic          wr_ptr, rd_ptr;
  logic [1:0]    count, count_next;
  logic          in_ready_q;
  logic          accept, deliver;
  logic [MW-1:0] out_next;

  assign in_ready = in_ready_q & ~rst;
  assign accept   = in_valid & in_ready;
  assign deliver  = out_valid & out_ready;

  always_comb begin
    count_next = count + {1'b0, accept} - {1'b0, deliver};
    out_next   = out_data;
    // The head register is reloaded with whatever entry becomes the new head.
    if (deliver) begin
      if (count == 2'd2) out_next = mem[rd_ptr + 1'b1];
      else if (accept)   out_next = xf_data;
    end else if (accept && count == 2'd0) begin
      out_next = xf_data;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= xf_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      count      <= 2'd0;
      in_ready_q <= 1'b1;
      out_valid  <= 1'b0;
      out_data   <= '0;
      sat_flag   <= 1'b0;
      mat_cnt    <= 16'd0;
    end else begin
      if (accept)  wr_ptr <= wr_ptr + 1'b1;
      if (deliver) rd_ptr <= rd_ptr + 1'b1;
      count      <= count_next;
      in_ready_q <= (count_next != 2'd2);
      out_valid  <= (count_next != 2'd0);
      out_data   <= out_next;
      sat_flag   <= (sat_flag & ~sat_clr) | (accept & xf_sat);
      if (deliver) mat_cnt <= mat_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_hermitian_transpose_stream.sv
// Directed and table-driven checks of hermitian_transpose_stream at N=2 and N=4.
module tb_hermitian_transpose_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic         in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic [127:0] in_data = '0, out_data;
  logic [1:0]   in_mode = 2'b00;
  logic         sat_flag, sat_clr = 1'b0;
  logic [15:0]  mat_cnt;

  logic         in4_valid = 1'b0, in4_ready, out4_valid, out4_ready = 1'b1;
  logic [511:0] in4_data = '0, out4_data;
  logic [1:0]   in4_mode = 2'b01;
  logic         sat4_flag;
  logic [15:0]  mat4_cnt;

  hermitian_transpose_stream #(.N(2), .DW(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_mode(in_mode), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .sat_flag(sat_flag), .sat_clr(sat_clr), .mat_cnt(mat_cnt));

  hermitian_transpose_stream #(.N(4), .DW(16)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in4_valid), .in_ready(in4_ready), .in_data(in4_data),
    .in_mode(in4_mode), .out_valid(out4_valid), .out_ready(out4_ready), .out_data(out4_data),
    .sat_flag(sat4_flag), .sat_clr(1'b0), .mat_cnt(mat4_cnt));

  int errs = 0;
  int checks = 0;
  logic [15:0] exp_cnt = 16'd0;

  task automatic chk_bit(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk_vec(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] el(input logic [15:0] re, input logic [15:0] im);
    return {re, im};
  endfunction

  // Reference for N=2: explicit element unpack, reorder and conjugate.
  function automatic logic [127:0] model2(input logic [127:0] d, input logic [1:0] m);
    logic [31:0] e [2][2];
    logic [31:0] x;
    logic [127:0] o;
    e[0][0] = d[127:96]; e[0][1] = d[95:64]; e[1][0] = d[63:32]; e[1][1] = d[31:0];
    o = '0;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 2; c++) begin
        x = (m == 2'b01 || m == 2'b10) ? e[c][r] : e[r][c];
        if (m[1]) x[15:0] = (x[15:0] == 16'h8000) ? 16'h7FFF : (16'h0000 - x[15:0]);
        o[127-(r*2+c)*32 -: 32] = x;
      end
    end
    return o;
  endfunction

  typedef struct {
    logic [1:0]   mode;
    logic [127:0] din;
    logic [127:0] dexp;
    logic         sat;
  } vec_t;

  vec_t tv [8];
  logic [127:0] ma, mb, mc, mexp;
  logic [127:0] rq [$];

  initial begin
    ma = {el(16'd1, 16'd2), el(16'd3, 16'd4), el(16'd5, 16'd6), el(16'd7, 16'd8)};
    mb = {el(16'd1, 16'd2), el(16'd3, 16'd4), el(16'd5, 16'd6), el(16'd7, 16'h8000)};
    mc = {el(16'd1, 16'h7FFF), el(16'd3, 16'h8000), el(16'd5, 16'hFFFF), el(16'h8000, 16'h0000)};
    tv[0] = '{2'b01, ma, {el(16'd1, 16'd2), el(16'd5, 16'd6), el(16'd3, 16'd4), el(16'd7, 16'd8)}, 1'b0};
    tv[1] = '{2'b10, ma, {el(16'd1, 16'hFFFE), el(16'd5, 16'hFFFA), el(16'd3, 16'hFFFC), el(16'd7, 16'hFFF8)}, 1'b0};
    tv[2] = '{2'b00, ma, ma, 1'b0};
    tv[3] = '{2'b11, ma, {el(16'd1, 16'hFFFE), el(16'd3, 16'hFFFC), el(16'd5, 16'hFFFA), el(16'd7, 16'hFFF8)}, 1'b0};
    tv[4] = '{2'b11, mb, {el(16'd1, 16'hFFFE), el(16'd3, 16'hFFFC), el(16'd5, 16'hFFFA), el(16'd7, 16'h7FFF)}, 1'b1};
    tv[5] = '{2'b01, mb, {el(16'd1, 16'd2), el(16'd5, 16'd6), el(16'd3, 16'd4), el(16'd7, 16'h8000)}, 1'b0};
    tv[6] = '{2'b10, mc, {el(16'd1, 16'h8001), el(16'd5, 16'h0001), el(16'd3, 16'h7FFF), el(16'h8000, 16'h0000)}, 1'b1};
    tv[7] = '{2'b00, mc, mc, 1'b0};

    // Reset state, including in_ready low while rst is held.
    repeat (2) tick();
    chk_bit("rst_in_ready", in_ready, 1'b0);
    chk_bit("rst_out_valid", out_valid, 1'b0);
    chk_vec("rst_out_data", 512'(out_data), 512'(0));
    chk_bit("rst_sat_flag", sat_flag, 1'b0);
    chk_vec("rst_mat_cnt", 512'(mat_cnt), 512'(0));
    rst = 1'b0;
    #1;
    chk_bit("post_rst_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;

    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = tv[i].din; in_mode = tv[i].mode;
      tick();
      chk_bit($sformatf("tv%0d_out_valid", i), out_valid, 1'b1);
      chk_vec($sformatf("tv%0d_out_data", i), 512'(out_data), 512'(tv[i].dexp));
      chk_bit($sformatf("tv%0d_sat_flag", i), sat_flag, tv[i].sat);
      in_valid = 1'b0; in_data = '0; sat_clr = 1'b1;
      tick();
      sat_clr = 1'b0;
      exp_cnt = exp_cnt + 16'd1;
      chk_bit($sformatf("tv%0d_drained", i), out_valid, 1'b0);
      chk_vec($sformatf("tv%0d_mat_cnt", i), 512'(mat_cnt), 512'(exp_cnt));
      chk_bit($sformatf("tv%0d_sat_cleared", i), sat_flag, 1'b0);
    end

    // Second saturation coincides with sat_clr: set must win.
    in_valid = 1'b1; in_data = mb; in_mode = 2'b11;
    tick();
    chk_bit("sat_first", sat_flag, 1'b1);
    sat_clr = 1'b1;
    tick();
    chk_bit("sat_set_wins", sat_flag, 1'b1);
    in_valid = 1'b0;
    tick();
    sat_clr = 1'b0;
    chk_bit("sat_cleared", sat_flag, 1'b0);
    exp_cnt = exp_cnt + 16'd2;
    chk_vec("sat_mat_cnt", 512'(mat_cnt), 512'(exp_cnt));

    // Backpressure: three offered, two fit, third taken after first deliver.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = ma; in_mode = 2'b01;
    tick();
    in_mode = 2'b10;
    tick();
    chk_bit("bp_full_in_ready", in_ready, 1'b0);
    chk_vec("bp_head0", 512'(out_data), 512'(tv[0].dexp));
    in_data = mb; in_mode = 2'b11;
    tick();
    chk_bit("bp_still_full", in_ready, 1'b0);
    chk_vec("bp_head_stable", 512'(out_data), 512'(tv[0].dexp));
    out_ready = 1'b1;
    tick();
    chk_vec("bp_head1", 512'(out_data), 512'(tv[1].dexp));
    chk_bit("bp_slot_freed", in_ready, 1'b1);
    tick();
    chk_vec("bp_head2", 512'(out_data), 512'(tv[4].dexp));
    in_valid = 1'b0; sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    exp_cnt = exp_cnt + 16'd3;
    chk_bit("bp_drained", out_valid, 1'b0);
    chk_vec("bp_mat_cnt", 512'(mat_cnt), 512'(exp_cnt));

    // Full-rate streaming against the model.
    for (int i = 0; i < 100; i++) begin
      chk_bit($sformatf("stream%0d_in_ready", i), in_ready, 1'b1);
      in_valid = 1'b1;
      in_data = {$urandom, $urandom, $urandom, $urandom};
      in_mode = 2'($urandom_range(0, 3));
      mexp = model2(in_data, in_mode);
      tick();
      chk_bit($sformatf("stream%0d_out_valid", i), out_valid, 1'b1);
      chk_vec($sformatf("stream%0d_out_data", i), 512'(out_data), 512'(mexp));
    end
    in_valid = 1'b0; sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    exp_cnt = exp_cnt + 16'd100;
    chk_vec("stream_mat_cnt", 512'(mat_cnt), 512'(exp_cnt));

    // 4x4 transpose, element by element.
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        in4_data[511-(r*4+c)*32 -: 32] = {16'(r * 16 + c), 16'(100 + r * 4 + c)};
    in4_valid = 1'b1;
    tick();
    in4_valid = 1'b0;
    chk_bit("n4_out_valid", out4_valid, 1'b1);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        chk_vec($sformatf("n4_elem_%0d_%0d", r, c), 512'(out4_data[511-(r*4+c)*32 -: 32]),
                512'({16'(c * 16 + r), 16'(100 + c * 4 + r)}));

    // Reset with two matrices buffered.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = ma; in_mode = 2'b00;
    tick();
    in_data = mc;
    tick();
    chk_bit("prerst_out_valid", out_valid, 1'b1);
    rst = 1'b1;
    #1;
    chk_bit("midrst_in_ready", in_ready, 1'b0);
    tick();
    chk_bit("rst2_out_valid", out_valid, 1'b0);
    chk_vec("rst2_mat_cnt", 512'(mat_cnt), 512'(0));
    chk_vec("rst2_out_data", 512'(out_data), 512'(0));
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_bit($sformatf("postrst%0d_out_valid", i), out_valid, 1'b0);
    end
    chk_vec("postrst_mat_cnt", 512'(mat_cnt), 512'(0));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
